memsync_responder: RTL and testbench
====================================

Name: memsync_responder

Overview:
- Responder side of the MEMSync allocate handshake.
- Each bank's MEMSync holds a level allocate request while its cache row is being (re)filled. This block arbitrates those requests round-robin and copies the row between the backing store and the cache-row buffer over a beat-level valid/ready memory port.
- When the copy completes it pulses sync to the requesting bank, which makes that MEMSync leave Allocate.
- Sits between MEMSyncTop and the off-chip/backing-memory adapter.

Parameters:
- BGWIDTH, 2, bank-group address width (BANKGROUPS=2**BGWIDTH)
- BAWIDTH, 2, bank address width (BANKSPERGROUP=2**BAWIDTH)
- CHWIDTH, 6, cache-row index width
- ADDRWIDTH, 17, row address width
- BEATWIDTH, 3, beat counter width; one row transfer = 2**BEATWIDTH beats

Ports:
- clk  in  1  clock; all logic on its rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- alloc_req  in  [BANKGROUPS][BANKSPERGROUP] x1  level; bank is in Allocate and needs a fill.
- wb_req  in  [BANKGROUPS][BANKSPERGROUP] x1  victim cache row is dirty; write back before fill. Sampled at grant.
- RowId  in  [BANKGROUPS][BANKSPERGROUP] x ADDRWIDTH  row to fill.
- evRowId  in  [BANKGROUPS][BANKSPERGROUP] x ADDRWIDTH  victim row address for writeback.
- cRowId  in  [BANKGROUPS][BANKSPERGROUP] x CHWIDTH  cache row being (re)used.
- sync  out  [BANKGROUPS][BANKSPERGROUP] x1  one-cycle completion pulse to the granted bank.
- mem_valid  out  1  beat request valid.
- mem_ready  in  1  beat accepted when mem_valid && mem_ready.
- mem_we  out  1  1 = writeback (cache to memory), 0 = fill.
- mem_bg / mem_ba  out  BGWIDTH / BAWIDTH  bank of the transfer.
- mem_row  out  ADDRWIDTH  row address.
- mem_crow  out  CHWIDTH  cache row.
- mem_beat  out  BEATWIDTH  beat index.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; round-robin pointer to bank 0 (bg=0, ba=0); beat counter 0.
- Flat bank index = {bg,ba}.

FSM states: IDLE, WB, FILL, SYNC, GUARD.
- IDLE:
  - If any alloc_req is high, grant the first requester at or after the pointer, in increasing flat index with wrap-around.
  - Latch the granted bank's bg, ba, RowId, evRowId, cRowId and wb_req.
  - Next state: WB if the latched wb_req = 1, else FILL.
  - Pointer becomes granted+1, wrapping to 0 after the last bank.
- WB:
  - mem_valid=1, mem_we=1, mem_row=latched evRowId, mem_beat=beat counter.
  - Each accepted beat increments the counter.
  - On the accepted beat at counter = 2**BEATWIDTH-1: counter to 0, go to FILL.
- FILL:
  - Same as WB but mem_we=0 and mem_row=latched RowId.
  - Last accepted beat goes to SYNC.
- SYNC:
  - sync of the granted bank = 1 for exactly this cycle; all other sync bits 0; mem_valid=0.
  - Next state: GUARD.
- GUARD:
  - One cycle; no new grant. This absorbs the bank's alloc_req deassertion lag.
  - Next state: IDLE.
- A new grant in IDLE at cycle t drives mem_valid at t+1.
- Minimum request-to-sync latency with mem_ready held high: fill only = 2**BEATWIDTH+2 cycles; with writeback = 2*2**BEATWIDTH+2 cycles.
- mem_valid is held, and the mem_* fields are held stable, until mem_ready. A stalled beat never advances the counter.
- Request inputs are ignored outside IDLE. A bank that drops alloc_req after being granted still completes its transfer and gets sync (no abort).
- Simultaneous requests: only one is granted; the others stay pending and are served in round-robin order.
- Reset asserted mid-transfer: immediate return to IDLE with outputs 0; no sync is emitted for the interrupted bank.
- mem_beat wraps naturally at BEATWIDTH bits; the counter is exactly BEATWIDTH bits wide.

Test Plan:
- Reset, then alloc_req[0][0]=1, wb_req=0, RowId=0x1ABCD, cRowId=5, mem_ready=1 -> 8 beats with mem_we=0, mem_row=0x1ABCD, mem_crow=5, beats 0..7; sync[0][0] pulses once, 10 cycles after the request.
- alloc_req[1][2] with wb_req=1, evRowId=0x00042, RowId=0x00100 -> 8 writeback beats (mem_we=1, row 0x42), then 8 fill beats (row 0x100), then sync[1][2]; latency 18 cycles.
- mem_ready toggled 1,0,0,1,... during a fill -> mem_beat and mem_row stable while ready=0; exactly 8 accepted beats; single sync pulse.
- alloc_req[0][0], [0][3], [3][3] raised together and held until each bank's own sync -> grants in order 0, 3, 15; pointer wraps; next request from bank 0 is granted after 15.
- Bank 2 keeps alloc_req high one cycle after its sync -> no regrant (GUARD); exactly one sync pulse.
- reset_n pulled low mid-FILL at beat 4 -> mem_valid=0, busy=0, no sync; after release, a fresh request completes a full 8-beat fill.

Source files
------------

// File: rtl/memsync_responder.sv
// MEMSync allocate responder: round-robin arbitration of per-bank allocate
// requests, beat-level row copy (optional writeback, then fill) over a
// valid/ready memory port, and a one-cycle sync pulse to the granted bank.
module memsync_responder #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int CHWIDTH   = 6,
  parameter int ADDRWIDTH = 17,
  parameter int BEATWIDTH = 3
) (
  input  logic                                                          clk,
  input  logic                                                          reset_n,
  input  logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0]                         alloc_req,
  input  logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0]                         wb_req,
  input  logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][ADDRWIDTH-1:0]          RowId,
  input  logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][ADDRWIDTH-1:0]          evRowId,
  input  logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][CHWIDTH-1:0]            cRowId,
  output logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0]                         sync,
  output logic                                                          mem_valid,
  input  logic                                                          mem_ready,
  output logic                                                          mem_we,
  output logic [BGWIDTH-1:0]                                            mem_bg,
  output logic [BAWIDTH-1:0]                                            mem_ba,
  output logic [ADDRWIDTH-1:0]                                          mem_row,
  output logic [CHWIDTH-1:0]                                            mem_crow,
  output logic [BEATWIDTH-1:0]                                          mem_beat,
  output logic                                                          busy
);

  localparam int BIDX  = BGWIDTH + BAWIDTH;
  localparam int NBANK = 2**BIDX;

  typedef enum logic [2:0] {IDLE, WB, FILL, SYNC, GUARD} state_t;

  state_t                 state_q, state_d;
  logic [BIDX-1:0]        ptr_q, ptr_d;
  logic [BIDX-1:0]        gnt_q, gnt_d;
  logic [ADDRWIDTH-1:0]   row_q, row_d;
  logic [ADDRWIDTH-1:0]   evrow_q, evrow_d;
  logic [CHWIDTH-1:0]     crow_q, crow_d;
  logic [BEATWIDTH-1:0]   beat_q, beat_d;

  // Flat views: packed [bg][ba] flattens to index {bg,ba}
  logic [NBANK-1:0]                req_flat;
  logic [NBANK-1:0]                wb_flat;
  logic [NBANK-1:0][ADDRWIDTH-1:0] row_flat;
  logic [NBANK-1:0][ADDRWIDTH-1:0] evrow_flat;
  logic [NBANK-1:0][CHWIDTH-1:0]   crow_flat;
  logic [NBANK-1:0]                sync_flat;

  assign req_flat   = alloc_req;
  assign wb_flat    = wb_req;
  assign row_flat   = RowId;
  assign evrow_flat = evRowId;
  assign crow_flat  = cRowId;
  assign sync       = sync_flat;

  logic            found;
  logic [BIDX-1:0] pick;
  logic            last_beat;

  assign last_beat = (beat_q == '1);

  // Round-robin search: first requester at or after the pointer, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < NBANK; i++) begin
      if (!found && req_flat[ptr_q + BIDX'(i)]) begin
        found = 1'b1;
        pick  = ptr_q + BIDX'(i);
      end
    end
  end

  // Next-state and port outputs
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    row_d     = row_q;
    evrow_d   = evrow_q;
    crow_d    = crow_q;
    beat_d    = beat_q;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    sync_flat = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = pick;
          ptr_d   = pick + BIDX'(1);
          row_d   = row_flat[pick];
          evrow_d = evrow_flat[pick];
          crow_d  = crow_flat[pick];
          state_d = wb_flat[pick] ? WB : FILL;
        end
      end
      WB: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        if (mem_ready) begin
          beat_d = beat_q + BEATWIDTH'(1);
          if (last_beat) state_d = FILL;
        end
      end
      FILL: begin
        mem_valid = 1'b1;
        if (mem_ready) begin
          beat_d = beat_q + BEATWIDTH'(1);
          if (last_beat) state_d = SYNC;
        end
      end
      SYNC: begin
        sync_flat[gnt_q] = 1'b1;
        state_d          = GUARD;
      end
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_bg   = gnt_q[BIDX-1:BAWIDTH];
  assign mem_ba   = gnt_q[BAWIDTH-1:0];
  assign mem_row  = (state_q == WB) ? evrow_q : row_q;
  assign mem_crow = crow_q;
  assign mem_beat = beat_q;
  assign busy     = (state_q != IDLE);

  // State, grant latch and beat counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      row_q   <= '0;
      evrow_q <= '0;
      crow_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      row_q   <= row_d;
      evrow_q <= evrow_d;
      crow_q  <= crow_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_memsync_responder.sv
// Directed bench for memsync_responder with hand-computed expectations.
module tb_memsync_responder;
  localparam int NB = 16;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NB-1:0]        alloc_req, wb_req, sync;
  logic [NB-1:0][16:0]  row_id, ev_row_id;
  logic [NB-1:0][5:0]   c_row_id;
  logic                 mem_valid, mem_ready, mem_we, busy;
  logic [1:0]           mem_bg, mem_ba;
  logic [16:0]          mem_row;
  logic [5:0]           mem_crow;
  logic [2:0]           mem_beat;

  int checks = 0;
  int errors = 0;
  logic [3:0] pat = 4'b1001;  // ready pattern 1,0,0,1

  memsync_responder #(.BGWIDTH(2), .BAWIDTH(2), .CHWIDTH(6), .ADDRWIDTH(17), .BEATWIDTH(3)) dut (
    .clk(clk), .reset_n(reset_n), .alloc_req(alloc_req), .wb_req(wb_req),
    .RowId(row_id), .evRowId(ev_row_id), .cRowId(c_row_id), .sync(sync),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_bg(mem_bg), .mem_ba(mem_ba), .mem_row(mem_row), .mem_crow(mem_crow),
    .mem_beat(mem_beat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    alloc_req = '0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Called right after a negedge. Cycle 1 is the request cycle; latency is
  // counted inclusively up to the sync cycle.
  task automatic transfer(input int bank, input bit present, input bit stall, input int exp_lat);
    int cyc = 1;
    int wbn = 0;
    int filln = 0;
    int k = 0;
    bit done = 1'b0;
    bit exp_wb;
    bit ph_wb;
    exp_wb = wb_req[bank];
    if (present) alloc_req[bank] = 1'b1;
    mem_ready = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      cyc++;
      mem_ready = stall ? pat[k % 4] : 1'b1;
      k++;
      if (mem_valid) begin
        ph_wb = exp_wb && (wbn < 8);
        check("we", mem_we, ph_wb);
        check("row", mem_row, ph_wb ? ev_row_id[bank] : row_id[bank]);
        check("crow", mem_crow, c_row_id[bank]);
        check("bank", {mem_bg, mem_ba}, bank);
        check("beat", mem_beat, ph_wb ? wbn : filln);
        if (mem_ready) begin
          if (ph_wb) wbn++;
          else filln++;
        end
      end
      if (sync != '0) begin
        check("sync_onehot", sync, 32'(1) << bank);
        check("wb_beats", wbn, exp_wb ? 8 : 0);
        check("fill_beats", filln, 8);
        if (exp_lat > 0) check("latency", cyc, exp_lat);
        done = 1'b1;
      end
    end
    if (!done) check("sync_timeout", 0, 1);
    mem_ready = 1'b1;
    // Guard cycle: request still high here, must not be regranted
    @(negedge clk);
    check("guard_busy", busy, 1);
    check("guard_sync", sync, 0);
    alloc_req[bank] = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_sync", sync, 0);
  endtask

  initial begin
    wb_req    = '0;
    row_id    = '0;
    ev_row_id = '0;
    c_row_id  = '0;
    alloc_req = '0;
    mem_ready = 1'b0;
    reset_n   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", mem_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sync", sync, 0);
    check("rst_we", mem_we, 0);
    check("rst_row", mem_row, 0);
    check("rst_beat", mem_beat, 0);
    check("rst_crow", mem_crow, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Fill only, bank 0
    row_id[0] = 17'h1ABCD; c_row_id[0] = 6'd5;
    transfer(0, 1'b1, 1'b0, 10);
    @(negedge clk);
    check("no_regrant0", busy, 0);

    // Writeback then fill, bg=1 ba=2 -> flat 6
    wb_req[6] = 1'b1; ev_row_id[6] = 17'h00042; row_id[6] = 17'h00100; c_row_id[6] = 6'd7;
    transfer(6, 1'b1, 1'b0, 18);

    // Fill with ready stalls, flat 9
    row_id[9] = 17'h15555; c_row_id[9] = 6'h2A;
    transfer(9, 1'b1, 1'b1, 0);

    // Reset mid-fill at beat 4, bank 2
    row_id[2] = 17'h0ABCD; c_row_id[2] = 6'd3;
    alloc_req[2] = 1'b1;
    mem_ready = 1'b1;
    begin
      bit hit = 1'b0;
      for (int n = 0; n < 50 && !hit; n++) begin
        @(negedge clk);
        if (mem_valid && mem_beat == 3'd4) hit = 1'b1;
      end
      check("reach_beat4", hit, 1);
    end
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", mem_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sync", sync, 0);
    check("mid_rst_beat", mem_beat, 0);
    alloc_req = '0;
    @(negedge clk);
    check("mid_rst_sync2", sync, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_sync", sync, 0);
    transfer(2, 1'b1, 1'b0, 10);

    // Round-robin from pointer 0: 0, 3, 15, then wrap back to 0
    do_reset();
    row_id[3] = 17'h00333; c_row_id[3] = 6'd33; wb_req[3] = 1'b1; ev_row_id[3] = 17'h1F00F;
    row_id[15] = 17'h0FFFF; c_row_id[15] = 6'd63;
    alloc_req[0] = 1'b1; alloc_req[3] = 1'b1; alloc_req[15] = 1'b1;
    transfer(0, 1'b0, 1'b0, 10);
    transfer(3, 1'b0, 1'b0, 0);
    transfer(15, 1'b0, 1'b0, 0);
    alloc_req[3] = 1'b1; alloc_req[0] = 1'b1;
    transfer(0, 1'b0, 1'b0, 0);
    transfer(3, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=0x0 exp=0x1");
    $fatal(1, "timeout");
  end
endmodule
